// File: rtl/maq_pkg.sv
// Shared definitions for the minutes/hours stage of the clock:
// state encoding, BCD digit limits and the mode sequencing helper.
package maq_pkg;

    localparam logic [1:0] EST_RODANDO     = 2'd0;
    localparam logic [1:0] EST_AJUSTE_HORA = 2'd1;
    localparam logic [1:0] EST_AJUSTE_MIN  = 2'd2;
    localparam logic [1:0] EST_ILEGAL      = 2'd3;

    typedef enum logic [1:0] {
        RODANDO     = EST_RODANDO,
        AJUSTE_HORA = EST_AJUSTE_HORA,
        AJUSTE_MIN  = EST_AJUSTE_MIN,
        ILEGAL      = EST_ILEGAL
    } estado_t;

    localparam logic [3:0] LSD_MAX        = 4'd9;
    localparam logic [2:0] MIN_MSD_MAX    = 3'd5;
    localparam logic [1:0] HOR_MSD_MAX    = 2'd2;
    localparam logic [3:0] HOR_LSD_MAX_23 = 4'd3;

    // Mode button cycles through the three legal states; anything else recovers to RODANDO.
    function automatic estado_t proximo_estado(input estado_t atual);
        case (atual)
            RODANDO:     return AJUSTE_HORA;
            AJUSTE_HORA: return AJUSTE_MIN;
            default:     return RODANDO;
        endcase
    endfunction

endpackage

// File: rtl/maq_borda.sv
// Rising-edge detector: one-cycle pulse on each low-to-high transition of i_in.
module maq_borda (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_in,
    output logic o_pulse
);

    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_in;
        end
    end

    assign o_pulse = i_in & ~r_prev;

endmodule

// File: rtl/maq_mh.sv
// Minutes/hours stage of a 24h BCD clock with a three-state time-setting mode
// (running, set hours, set minutes) driven by a mode and an increment button.
module maq_mh
    import maq_pkg::*;
(
    input  logic       maqmh_clock,
    input  logic       maqmh_reset,
    input  logic       maqmh_inc_minuto,
    input  logic       maqmh_btn_modo,
    input  logic       maqmh_btn_inc,
    output logic [3:0] maqmh_min_lsd,
    output logic [2:0] maqmh_min_msd,
    output logic [3:0] maqmh_hor_lsd,
    output logic [1:0] maqmh_hor_msd,
    output logic [1:0] maqmh_estado,
    output logic       maqmh_inc_dia
);

    estado_t    r_estado;
    estado_t    w_estado_nxt;
    logic [3:0] r_min_lsd, w_min_lsd_nxt;
    logic [2:0] r_min_msd, w_min_msd_nxt;
    logic [3:0] r_hor_lsd, w_hor_lsd_nxt;
    logic [1:0] r_hor_msd, w_hor_msd_nxt;
    logic       w_modo_borda;
    logic       w_inc_min;
    logic       w_inc_hor;
    logic       w_min_max;
    logic       w_hor_max;

    maq_borda u_borda_modo (
        .i_clk   (maqmh_clock),
        .i_rst_n (maqmh_reset),
        .i_in    (maqmh_btn_modo),
        .o_pulse (w_modo_borda)
    );

    assign w_min_max = (r_min_msd == MIN_MSD_MAX) && (r_min_lsd == LSD_MAX);
    assign w_hor_max = (r_hor_msd == HOR_MSD_MAX) && (r_hor_lsd == HOR_LSD_MAX_23);

    // Increments are decided by the state before any mode edge takes effect.
    always_comb begin
        w_estado_nxt = r_estado;
        w_inc_min    = 1'b0;
        w_inc_hor    = 1'b0;
        case (r_estado)
            RODANDO: begin
                w_inc_min = maqmh_inc_minuto;
                w_inc_hor = maqmh_inc_minuto & w_min_max;
            end
            AJUSTE_HORA: w_inc_hor = maqmh_btn_inc;
            AJUSTE_MIN:  w_inc_min = maqmh_btn_inc;
            default: ;
        endcase
        if (w_modo_borda || (r_estado == ILEGAL)) begin
            w_estado_nxt = proximo_estado(r_estado);
        end
    end

    always_comb begin
        w_min_lsd_nxt = r_min_lsd;
        w_min_msd_nxt = r_min_msd;
        if (w_inc_min) begin
            if (r_min_lsd == LSD_MAX) begin
                w_min_lsd_nxt = 4'd0;
                w_min_msd_nxt = (r_min_msd == MIN_MSD_MAX) ? 3'd0 : r_min_msd + 3'd1;
            end else begin
                w_min_lsd_nxt = r_min_lsd + 4'd1;
            end
        end
    end

    always_comb begin
        w_hor_lsd_nxt = r_hor_lsd;
        w_hor_msd_nxt = r_hor_msd;
        if (w_inc_hor) begin
            if (w_hor_max) begin
                w_hor_lsd_nxt = 4'd0;
                w_hor_msd_nxt = 2'd0;
            end else if (r_hor_lsd == LSD_MAX) begin
                w_hor_lsd_nxt = 4'd0;
                w_hor_msd_nxt = r_hor_msd + 2'd1;
            end else begin
                w_hor_lsd_nxt = r_hor_lsd + 4'd1;
            end
        end
    end

    always_ff @(posedge maqmh_clock or negedge maqmh_reset) begin
        if (!maqmh_reset) begin
            r_estado  <= RODANDO;
            r_min_lsd <= 4'd0;
            r_min_msd <= 3'd0;
            r_hor_lsd <= 4'd0;
            r_hor_msd <= 2'd0;
        end else begin
            r_estado  <= w_estado_nxt;
            r_min_lsd <= w_min_lsd_nxt;
            r_min_msd <= w_min_msd_nxt;
            r_hor_lsd <= w_hor_lsd_nxt;
            r_hor_msd <= w_hor_msd_nxt;
        end
    end

    assign maqmh_min_lsd = r_min_lsd;
    assign maqmh_min_msd = r_min_msd;
    assign maqmh_hor_lsd = r_hor_lsd;
    assign maqmh_hor_msd = r_hor_msd;
    assign maqmh_estado  = r_estado;
    assign maqmh_inc_dia = (r_estado == RODANDO) && maqmh_inc_minuto && w_min_max && w_hor_max;

endmodule

// File: tb/tb_maq_mh.sv
// Self-checking bench for maq_mh: directed scenarios plus a randomized run,
// all compared against an integer minutes/hours/mode model.
module tb_maq_mh;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       modo = 1'b0;
    logic       inc = 1'b0;
    logic       minuto = 1'b0;
    logic [3:0] min_lsd;
    logic [2:0] min_msd;
    logic [3:0] hor_lsd;
    logic [1:0] hor_msd;
    logic [1:0] estado;
    logic       dia;

    int pass_cnt = 0;
    int total_cnt = 0;

    int m_min;
    int m_hor;
    int m_st;
    bit m_prev;

    always #5 clk = ~clk;

    maq_mh dut (
        .maqmh_clock      (clk),
        .maqmh_reset      (rst_n),
        .maqmh_inc_minuto (minuto),
        .maqmh_btn_modo   (modo),
        .maqmh_btn_inc    (inc),
        .maqmh_min_lsd    (min_lsd),
        .maqmh_min_msd    (min_msd),
        .maqmh_hor_lsd    (hor_lsd),
        .maqmh_hor_msd    (hor_msd),
        .maqmh_estado     (estado),
        .maqmh_inc_dia    (dia)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [12:0] obs_time();
        return {hor_msd, hor_lsd, min_msd, min_lsd};
    endfunction

    function automatic logic [12:0] mk_time(input int h, input int m);
        logic [1:0] hm;
        logic [3:0] hl;
        logic [2:0] mm;
        logic [3:0] ml;
        hm = 2'(h / 10);
        hl = 4'(h % 10);
        mm = 3'(m / 10);
        ml = 4'(m % 10);
        return {hm, hl, mm, ml};
    endfunction

    // Model: one clock of the spec's behaviour in integer arithmetic.
    task automatic tick(input bit a_modo, input bit a_inc, input bit a_min,
                        output bit dia_obs, output bit dia_exp);
        bit borda;
        @(negedge clk);
        modo = a_modo;
        inc = a_inc;
        minuto = a_min;
        #1;
        dia_exp = (m_st == 0) && a_min && (m_hor == 23) && (m_min == 59);
        dia_obs = dia;
        @(posedge clk);
        borda = a_modo && !m_prev;
        m_prev = a_modo;
        if (m_st == 0 && a_min) begin
            m_min = m_min + 1;
            if (m_min == 60) begin
                m_min = 0;
                m_hor = (m_hor + 1) % 24;
            end
        end else if (m_st == 1 && a_inc) begin
            m_hor = (m_hor + 1) % 24;
        end else if (m_st == 2 && a_inc) begin
            m_min = (m_min + 1) % 60;
        end
        if (borda) m_st = (m_st + 1) % 3;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        modo = 1'b0;
        inc = 1'b0;
        minuto = 1'b0;
        m_min = 0;
        m_hor = 0;
        m_st = 0;
        m_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press();
        bit o, e;
        tick(1'b1, 1'b0, 1'b0, o, e);
        tick(1'b0, 1'b0, 1'b0, o, e);
    endtask

    task automatic incs(input int n);
        bit o, e;
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'b0, o, e);
        tick(1'b0, 1'b0, 1'b0, o, e);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total_cnt++;
        if (obs_time() !== 13'd0) $display("FAIL reset_time obs=%h exp=%h", obs_time(), 13'd0);
        else pass_cnt++;
        total_cnt++;
        if (estado !== 2'd0) $display("FAIL reset_state obs=%0d exp=0", estado);
        else pass_cnt++;
        total_cnt++;
        if (dia !== 1'b0) $display("FAIL reset_dia obs=%b exp=0", dia);
        else pass_cnt++;
    endtask

    task automatic test_hour_rollover();
        bit o, e;
        int dia_hits;
        dia_hits = 0;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            tick(1'b0, 1'b0, 1'b1, o, e);
            if (o) dia_hits++;
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                tick(1'b0, 1'b0, 1'b0, o, e);
                if (o) dia_hits++;
            end
        end
        total_cnt++;
        if (obs_time() !== mk_time(1, 0) || obs_time() !== mk_time(m_hor, m_min))
            $display("FAIL rollover_time obs=%0d%0d:%0d%0d exp=01:00", hor_msd, hor_lsd, min_msd, min_lsd);
        else pass_cnt++;
        total_cnt++;
        if (dia_hits != 0) $display("FAIL rollover_dia obs=%0d pulses exp=0", dia_hits);
        else pass_cnt++;
    endtask

    task automatic test_day_carry();
        bit o, e;
        do_reset();
        press();
        incs(23);
        press();
        incs(59);
        press();
        total_cnt++;
        if (obs_time() !== mk_time(23, 59) || estado !== 2'd0)
            $display("FAIL preload obs=%0d%0d:%0d%0d st=%0d exp=23:59 st=0", hor_msd, hor_lsd, min_msd, min_lsd, estado);
        else pass_cnt++;
        tick(1'b0, 1'b0, 1'b1, o, e);
        total_cnt++;
        if (o !== 1'b1 || e !== 1'b1) $display("FAIL day_carry_dia obs=%b exp=1", o);
        else pass_cnt++;
        total_cnt++;
        if (obs_time() !== mk_time(0, 0)) $display("FAIL day_carry_time obs=%h exp=%h", obs_time(), mk_time(0, 0));
        else pass_cnt++;
    endtask

    task automatic test_adj_hora();
        bit o, e;
        int dia_hits;
        dia_hits = 0;
        do_reset();
        press();
        for (int i = 0; i < 25; i++) begin
            tick(1'b0, 1'b1, i[0], o, e);
            if (o) dia_hits++;
        end
        total_cnt++;
        if (estado !== 2'd1 || obs_time() !== mk_time(1, 0))
            $display("FAIL adj_hora obs=%0d%0d:%0d%0d st=%0d exp=01:00 st=1", hor_msd, hor_lsd, min_msd, min_lsd, estado);
        else pass_cnt++;
        total_cnt++;
        if (dia_hits != 0) $display("FAIL adj_hora_dia obs=%0d pulses exp=0", dia_hits);
        else pass_cnt++;
    endtask

    task automatic test_adj_min();
        bit o, e;
        do_reset();
        for (int i = 0; i < 58; i++) tick(1'b0, 1'b0, 1'b1, o, e);
        press();
        press();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, i[0], o, e);
        total_cnt++;
        if (estado !== 2'd2 || obs_time() !== mk_time(0, 1))
            $display("FAIL adj_min obs=%0d%0d:%0d%0d st=%0d exp=00:01 st=2", hor_msd, hor_lsd, min_msd, min_lsd, estado);
        else pass_cnt++;
    endtask

    task automatic test_mode_hold();
        bit o, e;
        do_reset();
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0, o, e);
        tick(1'b0, 1'b0, 1'b0, o, e);
        total_cnt++;
        if (estado !== 2'd1) $display("FAIL mode_hold st obs=%0d exp=1", estado);
        else pass_cnt++;
        incs(12);
        press();
        incs(34);
        press();
        tick(1'b1, 1'b0, 1'b1, o, e);
        total_cnt++;
        if (estado !== 2'd1 || obs_time() !== mk_time(12, 35))
            $display("FAIL mode_with_minute obs=%0d%0d:%0d%0d st=%0d exp=12:35 st=1", hor_msd, hor_lsd, min_msd, min_lsd, estado);
        else pass_cnt++;
        // Mode edge with inc in AJUSTE_HORA: hour bumps, state advances.
        tick(1'b0, 1'b0, 1'b0, o, e);
        tick(1'b1, 1'b1, 1'b0, o, e);
        total_cnt++;
        if (estado !== 2'd2 || obs_time() !== mk_time(13, 35))
            $display("FAIL mode_with_inc obs=%0d%0d:%0d%0d st=%0d exp=13:35 st=2", hor_msd, hor_lsd, min_msd, min_lsd, estado);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        bit o, e;
        do_reset();
        press();
        incs(7);
        press();
        incs(42);
        total_cnt++;
        if (estado !== 2'd2 || obs_time() !== mk_time(7, 42))
            $display("FAIL pre_async obs=%0d%0d:%0d%0d st=%0d exp=07:42 st=2", hor_msd, hor_lsd, min_msd, min_lsd, estado);
        else pass_cnt++;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (obs_time() !== 13'd0 || estado !== 2'd0)
            $display("FAIL async_reset obs=%h st=%0d exp=0 st=0", obs_time(), estado);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        m_min = 0;
        m_hor = 0;
        m_st = 0;
        m_prev = 1'b0;
        tick(1'b0, 1'b1, 1'b1, o, e);
        total_cnt++;
        if (obs_time() !== mk_time(0, 1) || estado !== 2'd0)
            $display("FAIL resume obs=%0d%0d:%0d%0d st=%0d exp=00:01 st=0", hor_msd, hor_lsd, min_msd, min_lsd, estado);
        else pass_cnt++;
    endtask

    task automatic test_random();
        bit o, e;
        bit a_modo, a_inc, a_min;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            a_modo = ($urandom_range(0, 7) == 0);
            a_inc = ($urandom_range(0, 1) == 1);
            a_min = ($urandom_range(0, 1) == 1);
            tick(a_modo, a_inc, a_min, o, e);
            total_cnt++;
            if (o !== e || obs_time() !== mk_time(m_hor, m_min) || estado !== 2'(m_st))
                $display("FAIL random[%0d] obs=%0d%0d:%0d%0d st=%0d dia=%b exp=%02d:%02d st=%0d dia=%b",
                         i, hor_msd, hor_lsd, min_msd, min_lsd, estado, o, m_hor, m_min, m_st, e);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_hour_rollover();
        test_day_carry();
        test_adj_hora();
        test_adj_min();
        test_mode_hold();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/maq_mh.md
MAQ_MH -- requirements
Module: maq_mh

Interface
REQ-001 SHALL have port maqmh_clock, input, 1 bit: the same tick clock that drives the seconds stage, rising-edge active.
REQ-002 SHALL have port maqmh_reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port maqmh_inc_minuto, input, 1 bit: the seconds-stage carry, high for the one tick in which seconds = 59.
REQ-004 SHALL have port maqmh_btn_modo, input, 1 bit: mode button, active-high, already debounced and synchronous to maqmh_clock.
REQ-005 SHALL have port maqmh_btn_inc, input, 1 bit: increment button, active-high, already debounced and synchronous to maqmh_clock.
REQ-006 SHALL have output maqmh_min_lsd, 4 bits: BCD minute units, range 0..9.
REQ-007 SHALL have output maqmh_min_msd, 3 bits: BCD minute tens, range 0..5.
REQ-008 SHALL have output maqmh_hor_lsd, 4 bits: BCD hour units, range 0..9.
REQ-009 SHALL have output maqmh_hor_msd, 2 bits: BCD hour tens, range 0..2.
REQ-010 SHALL have output maqmh_estado, 2 bits: current state encoding, used by the display to blink the field being set.
REQ-011 SHALL have output maqmh_inc_dia, 1 bit: day carry for a downstream calendar stage.

Function
REQ-012 SHALL implement a three-state machine: RODANDO=2'd0, AJUSTE_HORA=2'd1, AJUSTE_MIN=2'd2; 2'd3 is illegal and SHALL return to RODANDO on the next edge.
REQ-013 SHALL detect the rising edge of maqmh_btn_modo with a registered previous-value flop, so each press produces exactly one transition.
REQ-014 SHALL advance the state on each detected mode edge: RODANDO -> AJUSTE_HORA -> AJUSTE_MIN -> RODANDO.
REQ-015 In RODANDO with maqmh_inc_minuto=1, SHALL increment minutes on that edge: units 9 -> 0 with tens +1, and 59 -> 00 with hours +1.
REQ-016 Hours SHALL count 00..23: units 9 -> 0 with tens +1, and 23 -> 00.
REQ-017 SHALL assert maqmh_inc_dia combinationally when state = RODANDO, time = 23:59 and maqmh_inc_minuto = 1; otherwise 0.
REQ-018 In AJUSTE_HORA, each clock with maqmh_btn_inc=1 SHALL increment hours by 1 (level-sensitive, auto-repeat once per tick), wrapping 23 -> 00 with no effect on minutes or maqmh_inc_dia.
REQ-019 In AJUSTE_MIN, each clock with maqmh_btn_inc=1 SHALL increment minutes by 1, wrapping 59 -> 00 with no carry into hours.
REQ-020 In both AJUSTE states, maqmh_inc_minuto SHALL be ignored, so time is frozen apart from button increments.
REQ-021 A mode edge and maqmh_btn_inc=1 in the same cycle: the state transition SHALL take effect, and the increment SHALL apply per the state before the edge.
REQ-022 A mode edge and maqmh_inc_minuto=1 in the same cycle in RODANDO: the minute increment SHALL occur, and the state SHALL move to AJUSTE_HORA.
REQ-023 All increments SHALL use fixed-width BCD arithmetic; no digit SHALL ever leave its legal range.
REQ-024 Outputs SHALL be driven directly from registers, with zero added latency, except maqmh_inc_dia, which is combinational.

Reset
REQ-025 On maqmh_reset=0, asynchronously, the block SHALL force: all digits = 0 (00:00), state = RODANDO, mode-edge flop = 0, and hence maqmh_inc_dia = 0.
REQ-026 Reset asserted mid-adjustment SHALL discard the adjustment in progress; after release, the block SHALL resume counting from 00:00 in RODANDO.

Structure
REQ-027 Package maq_pkg SHALL hold the state enum (estado_t), the digit limits (MIN_MSD_MAX=5, HOR_MSD_MAX=2, HOR_LSD_MAX_23=3) and the 2-bit state encodings.
REQ-028 Sub-module maq_borda (rising-edge detector: clock, active-low async reset, in, pulse out) SHALL be instantiated for maqmh_btn_modo.

Verification
REQ-029 Reset released, inc_minuto pulsed 60 times -> time reads 01:00 and inc_dia is never asserted.
REQ-030 Preload 23:59 in RODANDO and pulse inc_minuto once -> inc_dia=1 in that cycle, time reads 00:00 on the next edge.
REQ-031 One mode press, then btn_inc held 25 clocks -> state=1 and hours read 01 (wrap at 23 -> 00), minutes unchanged, inc_dia=0 throughout.
REQ-032 Two mode presses, minutes at 58, btn_inc held 3 clocks with inc_minuto toggling -> state=2, minutes read 01, hours unchanged.
REQ-033 Mode held high for 10 clocks -> exactly one transition; a mode edge coinciding with inc_minuto at 12:34 -> time reads 12:35 and state=1.
REQ-034 Reset asserted asynchronously, mid-cycle, during AJUSTE_MIN at 07:42 -> outputs go to 00:00 and state=0 before the next clock edge.
